ama_riscv_hazard_ctrl: RTL and testbench

- Parametrised pipeline hazard controller; successor to the fixed EX-only forwarding/decoder control path.
- Generalises operand forwarding to FWD_STAGES producer stages with nearest-stage priority.
- Adds sequential hazard handling: a load-use stall counter, a multi-cycle DMEM wait freeze, and a branch-mispredict flush window of configurable length.
- Sits beside the decoder in the control block; drives stall/clear/pc_we for IF/ID/EX and the forwarding muxes for ALU and branch-compare operands.

---
 rtl/ama_riscv_hazard_ctrl_pkg.sv | 15 +
 rtl/ama_riscv_fwd_match.sv | 34 +++
 rtl/ama_riscv_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_ama_riscv_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ama_riscv_hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: FSM states and forwarding
// source encodings.
package ama_riscv_hazard_ctrl_pkg;

   localparam int         FWD_STAGES_MAX = 4;
   localparam logic [2:0] FWD_SRC_RF     = 3'd0;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LD_STALL = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_FLUSH    = 2'd3
   } hz_state_e;

endpackage

// File: rtl/ama_riscv_fwd_match.sv
// Priority match of one source operand against all producer stages;
// the youngest (lowest-index) writer supplies the operand.
module ama_riscv_fwd_match
   import ama_riscv_hazard_ctrl_pkg::*;
#(
   parameter int FWD_STAGES = 2,
   parameter int RA_W       = 5
) (
   input  logic [RA_W-1:0]            rs_i,
   input  logic                       rs_used_i,
   input  logic [FWD_STAGES*RA_W-1:0] rd_stg_i,
   input  logic [FWD_STAGES-1:0]      reg_we_stg_i,
   input  logic [FWD_STAGES-1:0]      load_stg_i,
   output logic [2:0]                 sel_o,
   output logic                       load_hit_o
);

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves
      // it unassigned; otherwise synthesis would infer a latch.
      sel_o      = FWD_SRC_RF;
      load_hit_o = 1'b0;
      // Scan oldest to youngest so the lowest matching stage is written last.
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
         if (k < FWD_STAGES_MAX && rs_used_i && reg_we_stg_i[k] &&
             rd_stg_i[k*RA_W +: RA_W] != '0 &&
             rd_stg_i[k*RA_W +: RA_W] == rs_i) begin
            sel_o      = 3'(k + 1);
            load_hit_o = load_stg_i[k];
         end
      end
   end

endmodule

// File: rtl/ama_riscv_hazard_ctrl.sv
// Pipeline hazard controller: multi-stage operand forwarding plus load-use
// stall, DMEM wait freeze and mispredict flush sequencing.
module ama_riscv_hazard_ctrl
   import ama_riscv_hazard_ctrl_pkg::*;
#(
   parameter int FWD_STAGES = 2,
   parameter int LOAD_LAT   = 1,
   parameter int FLUSH_CYC  = 1,
   parameter int RA_W       = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [RA_W-1:0]            rs1_id,
   input  logic [RA_W-1:0]            rs2_id,
   input  logic                       rs1_used_id,
   input  logic                       rs2_used_id,
   input  logic [FWD_STAGES*RA_W-1:0] rd_stg,
   input  logic [FWD_STAGES-1:0]      reg_we_stg,
   input  logic [FWD_STAGES-1:0]      load_stg,
   input  logic                       mem_access,
   input  logic                       dmem_ready,
   input  logic                       mispredict_ex,
   output logic [2:0]                 fwd_a_sel,
   output logic [2:0]                 fwd_b_sel,
   output logic                       stall_if,
   output logic                       stall_id,
   output logic                       clear_if,
   output logic                       clear_id,
   output logic                       clear_ex,
   output logic                       pc_we,
   output logic                       busy
);

   localparam logic [2:0] LOAD_INIT  = 3'(LOAD_LAT - 1);
   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYC - 1);

   logic [2:0] sel_a, sel_b;
   logic       hit_a, hit_b;
   logic       load_use, mem_wait;
   hz_state_e  state_q, saved_q;
   logic [2:0] cnt_q;

   ama_riscv_fwd_match #(.FWD_STAGES(FWD_STAGES), .RA_W(RA_W)) u_fwd_a (
      .rs_i         (rs1_id),
      .rs_used_i    (rs1_used_id),
      .rd_stg_i     (rd_stg),
      .reg_we_stg_i (reg_we_stg),
      .load_stg_i   (load_stg),
      .sel_o        (sel_a),
      .load_hit_o   (hit_a)
   );

   ama_riscv_fwd_match #(.FWD_STAGES(FWD_STAGES), .RA_W(RA_W)) u_fwd_b (
      .rs_i         (rs2_id),
      .rs_used_i    (rs2_used_id),
      .rd_stg_i     (rd_stg),
      .reg_we_stg_i (reg_we_stg),
      .load_stg_i   (load_stg),
      .sel_o        (sel_b),
      .load_hit_o   (hit_b)
   );

   assign load_use = hit_a | hit_b;
   assign mem_wait = mem_access & ~dmem_ready;

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RUN;
         saved_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (mem_wait) begin
                  state_q <= ST_MEM_WAIT;
                  saved_q <= ST_RUN;
               end else if (mispredict_ex) begin
                  state_q <= ST_FLUSH;
                  cnt_q   <= FLUSH_INIT;
               end else if (load_use) begin
                  state_q <= ST_LD_STALL;
                  cnt_q   <= LOAD_INIT;
               end
            end
            ST_LD_STALL: begin
               if (mem_wait) begin
                  state_q <= ST_MEM_WAIT;
                  saved_q <= ST_LD_STALL;
               end else if (mispredict_ex) begin
                  state_q <= ST_FLUSH;
                  cnt_q   <= FLUSH_INIT;
               end else if (cnt_q == '0) begin
                  state_q <= ST_RUN;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            // The counter is left untouched so a frozen load stall resumes
            // exactly where it stopped.
            ST_MEM_WAIT: begin
               if (dmem_ready) state_q <= saved_q;
            end
            // The redirect is already in flight, so a DMEM wait here is left
            // to the flushed pipeline rather than freezing it.
            ST_FLUSH: begin
               if (mispredict_ex) begin
                  cnt_q <= FLUSH_INIT;
               end else if (cnt_q == '0) begin
                  state_q <= ST_RUN;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   always_comb begin
      fwd_a_sel = sel_a;
      fwd_b_sel = sel_b;
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      clear_if  = 1'b0;
      clear_id  = 1'b0;
      clear_ex  = 1'b0;
      pc_we     = 1'b1;
      busy      = (state_q != ST_RUN);
      unique case (state_q)
         ST_RUN: begin
            if (!mem_wait && mispredict_ex) begin
               clear_if = 1'b1;
               clear_id = 1'b1;
            end else if (!mem_wait && load_use) begin
               stall_if = 1'b1;
               stall_id = 1'b1;
               clear_ex = 1'b1;
               pc_we    = 1'b0;
            end
         end
         ST_LD_STALL: begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            clear_ex = 1'b1;
            pc_we    = 1'b0;
         end
         ST_MEM_WAIT: begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            pc_we    = 1'b0;
         end
         ST_FLUSH: begin
            clear_if = 1'b1;
            clear_id = 1'b1;
         end
         default: ;
      endcase
      // Reset drives a safe bubble into the pipe immediately, not at an edge.
      if (!rst) begin
         fwd_a_sel = FWD_SRC_RF;
         fwd_b_sel = FWD_SRC_RF;
         stall_if  = 1'b0;
         stall_id  = 1'b0;
         clear_if  = 1'b1;
         clear_id  = 1'b1;
         clear_ex  = 1'b1;
         pc_we     = 1'b0;
         busy      = 1'b0;
      end
   end

endmodule

// File: tb/tb_ama_riscv_hazard_ctrl.sv
// Self-checking bench: directed hazard scenarios plus random traffic against
// a cycle-count model of the stall/flush rules.
module tb_ama_riscv_hazard_ctrl;

   localparam int FWD_STAGES = 3;
   localparam int LOAD_LAT   = 2;
   localparam int FLUSH_CYC  = 3;
   localparam int RA_W       = 5;

   // {fwd_a, fwd_b, stall_if, stall_id, clear_if, clear_id, clear_ex, pc_we, busy}
   localparam logic [12:0] RST_VEC = {3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

   logic                       clk = 1'b0;
   logic                       rst = 1'b0;
   logic [RA_W-1:0]            rs1_id, rs2_id;
   logic                       rs1_used_id, rs2_used_id;
   logic [FWD_STAGES*RA_W-1:0] rd_stg;
   logic [FWD_STAGES-1:0]      reg_we_stg, load_stg;
   logic                       mem_access, dmem_ready, mispredict_ex;
   logic [2:0]                 fwd_a_sel, fwd_b_sel;
   logic                       stall_if, stall_id, clear_if, clear_id, clear_ex, pc_we, busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: remaining stall / flush cycles and a frozen flag.
   int          m_ld, m_fl;
   bit          m_wait;
   logic [12:0] obs;

   ama_riscv_hazard_ctrl #(
      .FWD_STAGES (FWD_STAGES),
      .LOAD_LAT   (LOAD_LAT),
      .FLUSH_CYC  (FLUSH_CYC),
      .RA_W       (RA_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rs1_id        (rs1_id),
      .rs2_id        (rs2_id),
      .rs1_used_id   (rs1_used_id),
      .rs2_used_id   (rs2_used_id),
      .rd_stg        (rd_stg),
      .reg_we_stg    (reg_we_stg),
      .load_stg      (load_stg),
      .mem_access    (mem_access),
      .dmem_ready    (dmem_ready),
      .mispredict_ex (mispredict_ex),
      .fwd_a_sel     (fwd_a_sel),
      .fwd_b_sel     (fwd_b_sel),
      .stall_if      (stall_if),
      .stall_id      (stall_id),
      .clear_if      (clear_if),
      .clear_id      (clear_id),
      .clear_ex      (clear_ex),
      .pc_we         (pc_we),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [12:0] get_obs();
      return {fwd_a_sel, fwd_b_sel, stall_if, stall_id, clear_if, clear_id, clear_ex, pc_we, busy};
   endfunction

   // Returns {load, sel}: first (youngest) stage writing the register.
   function automatic logic [3:0] ref_fwd(input logic [RA_W-1:0] rs, input logic used);
      if (!used || rs == '0) return 4'd0;
      for (int k = 0; k < FWD_STAGES; k++)
         if (reg_we_stg[k] && rd_stg[k*RA_W +: RA_W] == rs) return {load_stg[k], 3'(k + 1)};
      return 4'd0;
   endfunction

   task automatic model_reset();
      m_ld = 0; m_fl = 0; m_wait = 0;
   endtask

   task automatic set_idle();
      rs1_id = '0; rs2_id = '0; rs1_used_id = 0; rs2_used_id = 0;
      rd_stg = '0; reg_we_stg = '0; load_stg = '0;
      mem_access = 0; dmem_ready = 1; mispredict_ex = 0;
   endtask

   task automatic set_stage(input int k, input logic [RA_W-1:0] rd, input logic we, input logic ld);
      rd_stg[k*RA_W +: RA_W] = rd;
      reg_we_stg[k] = we;
      load_stg[k]   = ld;
   endtask

   // Checks one cycle mid-period, then advances the model across the edge.
   task automatic cycle(input string tag);
      logic [3:0]  fa, fb;
      logic        hit, memw, e_pc, e_st, e_cif, e_cex, e_busy;
      int          n_ld, n_fl;
      bit          n_wait;
      #4;
      fa = ref_fwd(rs1_id, rs1_used_id);
      fb = ref_fwd(rs2_id, rs2_used_id);
      hit  = fa[3] | fb[3];
      memw = mem_access & ~dmem_ready;
      e_pc = 1; e_st = 0; e_cif = 0; e_cex = 0; e_busy = 1;
      n_ld = m_ld; n_fl = m_fl; n_wait = m_wait;
      if (m_wait) begin
         e_pc = 0; e_st = 1;
         if (dmem_ready) n_wait = 0;
      end else if (m_fl > 0) begin
         e_cif = 1;
         n_fl = mispredict_ex ? FLUSH_CYC : m_fl - 1;
      end else if (m_ld > 0) begin
         e_pc = 0; e_st = 1; e_cex = 1;
         if (memw) n_wait = 1;
         else if (mispredict_ex) begin n_ld = 0; n_fl = FLUSH_CYC; end
         else n_ld = m_ld - 1;
      end else begin
         e_busy = 0;
         if (memw) n_wait = 1;
         else if (mispredict_ex) begin e_cif = 1; n_fl = FLUSH_CYC; end
         else if (hit) begin e_pc = 0; e_st = 1; e_cex = 1; n_ld = LOAD_LAT; end
      end
      obs = get_obs();
      check(tag, 32'(obs), 32'({fa[2:0], fb[2:0], e_st, e_st, e_cif, e_cif, e_cex, e_pc, e_busy}));
      @(posedge clk);
      m_ld = n_ld; m_fl = n_fl; m_wait = n_wait;
      #1;
   endtask

   initial begin
      int cnt;
      model_reset();
      set_idle();
      // Inputs that would forward, to prove reset forces the selects to 0.
      set_stage(0, 5'd5, 1, 0);
      rs1_id = 5'd5; rs1_used_id = 1;
      #2;
      check("rst_outputs", 32'(get_obs()), 32'(RST_VEC));
      @(posedge clk); #1;
      check("rst_hold", 32'(get_obs()), 32'(RST_VEC));
      #1 rst = 1;
      set_idle();

      // Forwarding priority
      set_stage(0, 5'd5, 1, 0); set_stage(1, 5'd5, 1, 0);
      rs1_id = 5'd5; rs1_used_id = 1;
      cycle("fwd_ex_mem");
      check("fwd_a_ex", 32'(obs[12:10]), 32'd1);
      set_stage(0, 5'd5, 0, 0);
      cycle("fwd_mem");
      check("fwd_a_mem", 32'(obs[12:10]), 32'd2);
      set_stage(0, 5'd0, 1, 0); set_stage(1, 5'd0, 1, 0); rs1_id = 5'd0;
      cycle("fwd_x0");
      check("fwd_a_x0", 32'(obs[12:10]), 32'd0);

      // Load-use: 1 + LOAD_LAT stall cycles, then MEM forward
      set_idle();
      set_stage(0, 5'd7, 1, 1); rs2_id = 5'd7; rs2_used_id = 1;
      cnt = 0;
      cycle("lu_hit"); cnt += int'(obs[6] & obs[2]);
      set_stage(0, 5'd0, 0, 0); set_stage(1, 5'd7, 1, 1);
      for (int i = 0; i < 2; i++) begin cycle("lu_stall"); cnt += int'(obs[6] & obs[2]); end
      check("lu_stall_cycles", 32'(cnt), 32'd3);
      set_stage(1, 5'd7, 1, 0);
      cycle("lu_done");
      check("lu_fwd_b_mem", 32'(obs[9:7]), 32'd2);
      check("lu_done_pc_we", 32'(obs[1]), 32'd1);

      // DMEM wait freezing an in-progress load stall
      set_idle();
      set_stage(0, 5'd7, 1, 1); rs2_id = 5'd7; rs2_used_id = 1;
      cycle("mw_hit");
      set_stage(0, 5'd0, 0, 0); set_stage(1, 5'd7, 1, 0);
      mem_access = 1; dmem_ready = 0;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin cycle("mw_low"); cnt += int'(obs[6] & ~obs[2] & ~obs[4]); end
      dmem_ready = 1;
      cycle("mw_ready"); cnt += int'(obs[6] & ~obs[2] & ~obs[4]);
      check("mw_freeze_cycles", 32'(cnt), 32'd4);
      mem_access = 0;
      cnt = 0;
      for (int i = 0; i < 3; i++) begin cycle("mw_resume"); cnt += int'(obs[2]); end
      check("mw_resume_stalls", 32'(cnt), 32'd2);
      check("mw_back_run", 32'(obs[0]), 32'd0);

      // Mispredict flush window and restart
      set_idle();
      mispredict_ex = 1;
      cnt = 0;
      cycle("mp_trig"); cnt += int'(obs[4] & obs[3]);
      mispredict_ex = 0;
      for (int i = 0; i < 5; i++) begin cycle("mp_flush"); cnt += int'(obs[4] & obs[3]); end
      check("mp_clear_cycles", 32'(cnt), 32'd4);
      mispredict_ex = 1; cycle("mp2_trig");
      mispredict_ex = 0; cycle("mp2_flush");
      mispredict_ex = 1; cycle("mp2_reload");
      mispredict_ex = 0;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin cycle("mp2_tail"); cnt += int'(obs[4]); end
      check("mp2_restart_cycles", 32'(cnt), 32'd3);

      // Load-use and mispredict together: flush wins
      set_idle();
      set_stage(0, 5'd7, 1, 1); rs2_id = 5'd7; rs2_used_id = 1; mispredict_ex = 1;
      cycle("both_trig");
      check("both_no_clear_ex", 32'(obs[2]), 32'd0);
      check("both_clear_if", 32'(obs[4]), 32'd1);
      set_idle();
      cycle("both_flush");
      check("both_no_ldstall", 32'(obs[2]), 32'd0);
      for (int i = 0; i < 3; i++) cycle("both_drain");

      // Asynchronous reset pulse between edges during a load stall
      set_stage(0, 5'd7, 1, 1); rs2_id = 5'd7; rs2_used_id = 1;
      cycle("ar_hit");
      set_idle();
      #2 rst = 0;
      #1 check("ar_outputs", 32'(get_obs()), 32'(RST_VEC));
      #1 rst = 1;
      model_reset();
      @(posedge clk); #1;
      cycle("ar_after");
      check("ar_busy", 32'(obs[0]), 32'd0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         rs1_id = RA_W'($urandom_range(0, 3));
         rs2_id = RA_W'($urandom_range(0, 3));
         rs1_used_id = ($urandom_range(0, 3) != 0);
         rs2_used_id = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < FWD_STAGES; k++)
            set_stage(k, RA_W'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 3) == 0));
         mem_access    = ($urandom_range(0, 5) == 0);
         dmem_ready    = ($urandom_range(0, 2) != 0);
         mispredict_ex = ($urandom_range(0, 9) == 0);
         cycle("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
